// File: rtl/ooo_pkg.sv
// Shared types for the out-of-order core: ROB entry layout and register pointers.
package ooo_pkg;

  localparam int ROB_DEF_DATA_W = 32;
  localparam int ROB_DEF_COUNT  = 32;
  localparam int ROB_PTR_W      = $clog2(ROB_DEF_COUNT);

  typedef logic [4:0] arf_ptr_t;

  // Entry layout at the default result width; the ROB keeps these fields
  // as parallel arrays so DATA_WIDTH can be overridden per instance.
  typedef struct packed {
    logic                      valid;
    logic                      done;
    logic                      dest_valid;
    arf_ptr_t                  arf_ptr;
    logic [ROB_DEF_DATA_W-1:0] data;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocate at tail, writeback by pointer,
// commit from head, with same-cycle writeback forwarding on operand lookup.
module reorder_buffer
  import ooo_pkg::*;
#(
  parameter int DATA_WIDTH = ROB_DEF_DATA_W,
  parameter int ROB_COUNT  = ROB_DEF_COUNT,
  localparam int PTR_W     = $clog2(ROB_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  alloc_valid_i,
  output logic                  alloc_ready_o,
  input  logic                  alloc_dest_valid_i,
  input  logic [4:0]            alloc_arf_ptr_i,
  output logic [PTR_W-1:0]      alloc_rob_ptr_o,
  input  logic                  wb_en_i,
  input  logic [PTR_W-1:0]      wb_rob_ptr_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  input  logic [PTR_W-1:0]      rd0_rob_ptr_i,
  input  logic [PTR_W-1:0]      rd1_rob_ptr_i,
  output logic                  rd0_done_o,
  output logic                  rd1_done_o,
  output logic [DATA_WIDTH-1:0] rd0_data_o,
  output logic [DATA_WIDTH-1:0] rd1_data_o,
  output logic                  commit_en_o,
  output logic                  commit_dest_valid_o,
  output logic [4:0]            commit_arf_ptr_o,
  output logic [PTR_W-1:0]      commit_rob_ptr_o,
  output logic [DATA_WIDTH-1:0] commit_data_o
);

  localparam logic [PTR_W:0] COUNT_FULL = (PTR_W+1)'(ROB_COUNT);

  logic [ROB_COUNT-1:0]  valid_q, done_q, dest_q;
  arf_ptr_t              arf_q  [ROB_COUNT];
  logic [DATA_WIDTH-1:0] data_q [ROB_COUNT];
  logic [PTR_W-1:0]      head_q, tail_q;
  logic [PTR_W:0]        count_q;

  logic alloc_fire, commit_fire, wb_fire;

  // Full check deliberately ignores a same-cycle commit.
  assign alloc_ready_o   = (count_q != COUNT_FULL) && !flush_i;
  assign alloc_rob_ptr_o = tail_q;
  assign alloc_fire      = alloc_valid_i && alloc_ready_o;

  // Writebacks to squashed/unallocated entries are dropped.
  assign wb_fire = wb_en_i && valid_q[wb_rob_ptr_i] && !flush_i;

  // Head retires only once its done bit is registered, so a writeback
  // to the head commits the following cycle at the earliest.
  assign commit_en_o         = valid_q[head_q] && done_q[head_q] && !flush_i;
  assign commit_fire         = commit_en_o;
  assign commit_dest_valid_o = dest_q[head_q] && commit_en_o;
  assign commit_arf_ptr_o    = arf_q[head_q];
  assign commit_rob_ptr_o    = head_q;
  assign commit_data_o       = data_q[head_q];

  // Operand lookup with writeback forwarding, shared by both read ports.
  function automatic logic lookup_hit(input logic [PTR_W-1:0] ptr);
    return wb_en_i && (wb_rob_ptr_i == ptr) && valid_q[ptr];
  endfunction

  // Read port results, including same-cycle forwarding from writeback.
  always_comb begin
    rd0_done_o = valid_q[rd0_rob_ptr_i] && (done_q[rd0_rob_ptr_i] || lookup_hit(rd0_rob_ptr_i));
    rd1_done_o = valid_q[rd1_rob_ptr_i] && (done_q[rd1_rob_ptr_i] || lookup_hit(rd1_rob_ptr_i));
    rd0_data_o = lookup_hit(rd0_rob_ptr_i) ? wb_data_i : data_q[rd0_rob_ptr_i];
    rd1_data_o = lookup_hit(rd1_rob_ptr_i) ? wb_data_i : data_q[rd1_rob_ptr_i];
  end

  // Entry array and pointer state: reset, flush, then alloc/writeback/commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      done_q  <= '0;
      dest_q  <= '0;
      for (int i = 0; i < ROB_COUNT; i++) begin
        arf_q[i]  <= '0;
        data_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // Alloc index never equals the commit index: that would need the
      // buffer to be both empty (no commit) and full (no alloc).
      if (alloc_fire) begin
        valid_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        dest_q[tail_q]  <= alloc_dest_valid_i;
        arf_q[tail_q]   <= alloc_arf_ptr_i;
        tail_q          <= tail_q + 1'b1;
      end
      if (wb_fire) begin
        done_q[wb_rob_ptr_i] <= 1'b1;
        data_q[wb_rob_ptr_i] <= wb_data_i;
      end
      if (commit_fire) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      count_q <= count_q + (PTR_W+1)'(alloc_fire) - (PTR_W+1)'(commit_fire);
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed table, hand sequences,
// and randomized traffic against a queue-based reference model.
module tb_reorder_buffer;

  localparam int DW = 32;
  localparam int N  = 32;
  localparam int PW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush_i, alloc_valid_i, alloc_ready_o, alloc_dest_valid_i;
  logic [4:0]    alloc_arf_ptr_i;
  logic [PW-1:0] alloc_rob_ptr_o;
  logic          wb_en_i;
  logic [PW-1:0] wb_rob_ptr_i, rd0_rob_ptr_i, rd1_rob_ptr_i;
  logic [DW-1:0] wb_data_i, rd0_data_o, rd1_data_o;
  logic          rd0_done_o, rd1_done_o;
  logic          commit_en_o, commit_dest_valid_o;
  logic [4:0]    commit_arf_ptr_o;
  logic [PW-1:0] commit_rob_ptr_o;
  logic [DW-1:0] commit_data_o;

  always #5 clk = ~clk;

  reorder_buffer #(.DATA_WIDTH(DW), .ROB_COUNT(N)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
    .alloc_dest_valid_i(alloc_dest_valid_i), .alloc_arf_ptr_i(alloc_arf_ptr_i),
    .alloc_rob_ptr_o(alloc_rob_ptr_o),
    .wb_en_i(wb_en_i), .wb_rob_ptr_i(wb_rob_ptr_i), .wb_data_i(wb_data_i),
    .rd0_rob_ptr_i(rd0_rob_ptr_i), .rd1_rob_ptr_i(rd1_rob_ptr_i),
    .rd0_done_o(rd0_done_o), .rd1_done_o(rd1_done_o),
    .rd0_data_o(rd0_data_o), .rd1_data_o(rd1_data_o),
    .commit_en_o(commit_en_o), .commit_dest_valid_o(commit_dest_valid_o),
    .commit_arf_ptr_o(commit_arf_ptr_o), .commit_rob_ptr_o(commit_rob_ptr_o),
    .commit_data_o(commit_data_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: an ordered list of in-flight instructions, oldest first.
  typedef struct {
    int            ptr;
    bit            done;
    bit            dest;
    int            arf;
    logic [DW-1:0] data;
  } ment_t;
  ment_t mq[$];
  int    mhead = 0, mtail = 0;

  // Effects of the applied cycle, committed to the model at the clock edge.
  bit            p_alloc, p_dest, p_fl, p_cen;
  int            p_arf, p_iw;
  logic [DW-1:0] p_wd;

  typedef struct {
    bit            a;
    int            arf;
    bit            we;
    int            wp;
    logic [DW-1:0] wd;
    int            r0;
    bit            e_ready;
    int            e_aptr;
    bit            e_cen;
    int            e_carf;
    logic [DW-1:0] e_cdata;
    int            e_crob;
    bit            e_r0done;
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int mfind(input int p);
    foreach (mq[i]) if (mq[i].ptr == p) return i;
    return -1;
  endfunction

  // Drive one cycle's inputs (called at negedge) and check outputs vs model.
  task automatic apply(input bit a, input bit d, input int arf, input bit we, input int wp,
                       input logic [DW-1:0] wd, input int r0, input int r1, input bit fl);
    int            rp [2];
    logic          rdone [2];
    logic [DW-1:0] rdata [2];
    bit            exp_ready, exp_cen, expd, hit;
    int            idx;
    alloc_valid_i      = a;
    alloc_dest_valid_i = d;
    alloc_arf_ptr_i    = arf[4:0];
    wb_en_i            = we;
    wb_rob_ptr_i       = wp[PW-1:0];
    wb_data_i          = wd;
    rd0_rob_ptr_i      = r0[PW-1:0];
    rd1_rob_ptr_i      = r1[PW-1:0];
    flush_i            = fl;
    #1;
    exp_ready = (mq.size() != N) && !fl;
    exp_cen   = (mq.size() > 0) && mq[0].done && !fl;
    chk("alloc_ready", alloc_ready_o, exp_ready);
    chk("alloc_ptr", alloc_rob_ptr_o, mtail);
    chk("commit_en", commit_en_o, exp_cen);
    chk("commit_ptr", commit_rob_ptr_o, mhead);
    if (exp_cen) begin
      chk("commit_arf", commit_arf_ptr_o, mq[0].arf);
      chk("commit_data", commit_data_o, mq[0].data);
      chk("commit_dest", commit_dest_valid_o, mq[0].dest);
    end else begin
      chk("commit_dest_idle", commit_dest_valid_o, 0);
    end
    rp[0] = r0; rp[1] = r1;
    rdone[0] = rd0_done_o; rdone[1] = rd1_done_o;
    rdata[0] = rd0_data_o; rdata[1] = rd1_data_o;
    for (int k = 0; k < 2; k++) begin
      idx  = mfind(rp[k]);
      hit  = we && (wp == rp[k]) && (idx >= 0);
      expd = (idx >= 0) && (mq[idx].done || hit);
      chk("rd_done", rdone[k], expd);
      if (expd) chk("rd_data", rdata[k], hit ? wd : mq[idx].data);
    end
    p_alloc = a && exp_ready;
    p_dest  = d;
    p_arf   = arf;
    p_fl    = fl;
    p_cen   = exp_cen;
    p_iw    = we ? mfind(wp) : -1;
    p_wd    = wd;
  endtask

  // Clock edge: advance the model, return at the next negedge.
  task automatic tick();
    ment_t e;
    @(posedge clk);
    if (p_fl) begin
      mq.delete();
      mhead = 0;
      mtail = 0;
    end else begin
      if (p_iw >= 0) begin
        mq[p_iw].done = 1'b1;
        mq[p_iw].data = p_wd;
      end
      if (p_cen) begin
        void'(mq.pop_front());
        mhead = (mhead + 1) % N;
      end
      if (p_alloc) begin
        e.ptr = mtail; e.done = 1'b0; e.dest = p_dest; e.arf = p_arf; e.data = '0;
        mq.push_back(e);
        mtail = (mtail + 1) % N;
      end
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, alloc_ready_o, 1);
    chk({tag, "_aptr"}, alloc_rob_ptr_o, 0);
    chk({tag, "_cen"}, commit_en_o, 0);
    chk({tag, "_cdest"}, commit_dest_valid_o, 0);
    chk({tag, "_carf"}, commit_arf_ptr_o, 0);
    chk({tag, "_crob"}, commit_rob_ptr_o, 0);
    chk({tag, "_cdata"}, commit_data_o, 0);
    chk({tag, "_rd0"}, {rd0_done_o, rd0_data_o}, 0);
    chk({tag, "_rd1"}, {rd1_done_o, rd1_data_o}, 0);
  endtask

  task automatic rand_cycle();
    int wp, r0, r1;
    wp = (mq.size() > 0 && $urandom_range(3) != 0) ? mq[$urandom_range(mq.size()-1)].ptr : $urandom_range(N-1);
    r0 = (mq.size() > 0 && $urandom_range(1) != 0) ? mq[$urandom_range(mq.size()-1)].ptr : $urandom_range(N-1);
    r1 = $urandom_range(N-1);
    apply($urandom_range(3) != 0, $urandom_range(1) != 0, $urandom_range(31),
          $urandom_range(2) != 0, wp, $urandom, r0, r1, $urandom_range(39) == 0);
    tick();
  endtask

  initial begin
    rst = 1'b0;
    flush_i = 0; alloc_valid_i = 0; alloc_dest_valid_i = 0; alloc_arf_ptr_i = 0;
    wb_en_i = 0; wb_rob_ptr_i = 0; wb_data_i = 0; rd0_rob_ptr_i = 0; rd1_rob_ptr_i = 0;
    #3;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // a, arf, we, wp, wd, r0 | ready, aptr, cen, carf, cdata, crob, r0done
    vt[0] = '{1, 5, 0, 0, 32'h0,  0, 1, 0, 0, 0, 32'h0,  0, 0};
    vt[1] = '{1, 6, 0, 0, 32'h0,  0, 1, 1, 0, 0, 32'h0,  0, 0};
    vt[2] = '{1, 7, 0, 0, 32'h0,  0, 1, 2, 0, 0, 32'h0,  0, 0};
    vt[3] = '{0, 0, 1, 1, 32'hAA, 1, 1, 3, 0, 0, 32'h0,  0, 1};
    vt[4] = '{0, 0, 1, 0, 32'h55, 1, 1, 3, 0, 0, 32'h0,  0, 1};
    vt[5] = '{0, 0, 0, 0, 32'h0,  2, 1, 3, 1, 5, 32'h55, 0, 0};
    vt[6] = '{0, 0, 0, 0, 32'h0,  1, 1, 3, 1, 6, 32'hAA, 1, 1};
    vt[7] = '{0, 0, 0, 0, 32'h0,  2, 1, 3, 0, 0, 32'h0,  2, 0};
    for (int i = 0; i < 8; i++) begin
      apply(vt[i].a, 1'b1, vt[i].arf, vt[i].we, vt[i].wp, vt[i].wd, vt[i].r0, 0, 1'b0);
      chk("vec_ready", alloc_ready_o, vt[i].e_ready);
      chk("vec_aptr", alloc_rob_ptr_o, vt[i].e_aptr);
      chk("vec_cen", commit_en_o, vt[i].e_cen);
      chk("vec_crob", commit_rob_ptr_o, vt[i].e_crob);
      chk("vec_r0done", rd0_done_o, vt[i].e_r0done);
      if (vt[i].e_cen) begin
        chk("vec_carf", commit_arf_ptr_o, vt[i].e_carf);
        chk("vec_cdata", commit_data_o, vt[i].e_cdata);
      end
      tick();
    end

    // Clear, then fill to capacity.
    apply(0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    for (int i = 0; i < N; i++) begin
      apply(1, 1, i % 32, 0, 0, 0, 0, 0, 0);
      tick();
    end
    apply(1, 1, 3, 1, 0, 32'hC0DE, 0, 0, 0);
    chk("full_ready", alloc_ready_o, 0);
    tick();
    // Full with head done: commit fires, allocation is refused this cycle.
    apply(1, 1, 4, 0, 0, 0, 0, 0, 0);
    chk("full_commit_en", commit_en_o, 1);
    chk("full_no_bypass", alloc_ready_o, 0);
    tick();
    // 33rd allocation wraps the tail back to 0.
    apply(1, 1, 8, 0, 0, 0, 0, 0, 0);
    chk("wrap_ready", alloc_ready_o, 1);
    chk("wrap_aptr", alloc_rob_ptr_o, 0);
    tick();
    // Same-cycle forwarding.
    apply(0, 0, 0, 1, 4, 32'h1234, 4, 0, 0);
    chk("fwd_done", rd0_done_o, 1);
    chk("fwd_data", rd0_data_o, 32'h1234);
    tick();
    // Flush with ready head and a writeback pending.
    apply(0, 0, 0, 1, 1, 32'h11, 0, 0, 0); tick();
    apply(1, 1, 2, 1, 2, 32'h22, 0, 0, 1);
    chk("flush_no_commit", commit_en_o, 0);
    chk("flush_no_alloc", alloc_ready_o, 0);
    tick();
    apply(0, 0, 0, 0, 0, 0, 3, 2, 0);
    chk("post_flush_aptr", alloc_rob_ptr_o, 0);
    chk("post_flush_crob", commit_rob_ptr_o, 0);
    chk("unalloc_lookup", rd0_done_o, 0);
    chk("post_flush_ready", alloc_ready_o, 1);
    tick();
    // Store: no architectural destination.
    apply(1, 0, 9, 0, 0, 0, 0, 0, 0); tick();
    apply(0, 0, 0, 1, 0, 32'h77, 0, 0, 0); tick();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("store_cen", commit_en_o, 1);
    chk("store_dest", commit_dest_valid_o, 0);
    tick();

    for (int i = 0; i < 600; i++) rand_cycle();

    // Asynchronous reset between clock edges.
    alloc_valid_i = 0; wb_en_i = 0; flush_i = 0;
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b1;
    mq.delete(); mhead = 0; mtail = 0;
    for (int i = 0; i < 200; i++) rand_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
